timer_counter: RTL and testbench

- Memory-mapped programmable down-counter placed directly downstream of the system bus bridge.
- Two instances exist: TC0 at 0x0000_7F00–0x0000_7F0B and TC1 at 0x0000_7F10–0x0000_7F1B.
- The bridge supplies the word address, write enable and write data, and returns the read data to the CPU.
- The block raises a level interrupt request, which is ORed into the CPU external hardware-interrupt inputs.

---
 rtl/timer_counter.sv | 131 +++++++++++++
 tb/tb_timer_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with a level interrupt.
// Register file is CTRL/PRESET/COUNT at word offsets 0..2; offset 3 is reserved.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam logic [1:0] OffCtrl   = 2'd0;
    localparam logic [1:0] OffPreset = 2'd1;
    localparam logic [1:0] OffCount  = 2'd2;

    localparam logic [1:0] ModeReload = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        en;
    logic [1:0]  mode;
    logic        im;

    assign en   = ctrl_q[0];
    assign mode = ctrl_q[2:1];
    assign im   = ctrl_q[3];

    // Base decode happens upstream; only the word offset is used here.
    logic unused_addr;
    assign unused_addr = ^Addr[31:4];

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d    = preset_q;
                irq_flag_d = 1'b0;
                state_d    = StCnt;
            end
            StCnt: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = StInt;
                end
            end
            StInt: begin
                // Modes 10/11 behave as one-shot.
                if (mode == ModeReload) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Bus write lands after the FSM update so a written EN wins over the FSM clear.
        if (WE) begin
            case (Addr[3:2])
                OffCtrl: begin
                    ctrl_d     = Din[3:0];
                    irq_flag_d = 1'b0;
                end
                OffPreset: begin
                    preset_d = Din;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            OffCtrl:   Dout = {28'b0, ctrl_q};
            OffPreset: Dout = preset_q;
            OffCount:  Dout = count_q;
            default:   Dout = '0;
        endcase
    end

    assign IRQ = im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter; expected values go through a scoreboard queue.
module tb_timer_counter;

    localparam logic [29:0] Base = 30'h0000_1FC0;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
        Addr = Base | 30'(off);
        WE   = 1'b1;
        Din  = data;
        tick();
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic compare_pop(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %h required nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        exp_t e;
        Addr  = Base | 30'(off);
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        #1;
        compare_pop(Dout);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        exp_t e;
        e.tag = tag;
        e.exp = {31'b0, exp};
        sb.push_back(e);
        #1;
        compare_pop({31'b0, IRQ});
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b1;
        Din   = 32'hFFFF_FFFF;
        Addr  = Base;

        // Reset with a write pending: reset must win.
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_reg("reset_dout", 2'(i), 32'h0);
        end
        chk_irq("reset_irq", 1'b0);
        reset = 1'b0;
        WE    = 1'b0;
        Din   = '0;
        tick();
        chk_reg("post_reset_ctrl", 2'd0, 32'h0);

        // One-shot, PRESET=5.
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        tick();
        tick();
        for (int i = 5; i >= 1; i--) begin
            chk_reg("oneshot_count", 2'd2, 32'(i));
            chk_irq("oneshot_irq_low", 1'b0);
            tick();
        end
        chk_reg("oneshot_count_zero", 2'd2, 32'h0);
        chk_irq("oneshot_irq_high", 1'b1);
        tick();
        chk_reg("oneshot_ctrl_en_clr", 2'd0, 32'h8);
        chk_irq("oneshot_irq_hold", 1'b1);
        tick();
        chk_irq("oneshot_irq_hold2", 1'b1);
        chk_reg("oneshot_count_hold", 2'd2, 32'h0);
        bus_write(2'd0, 32'h8);
        chk_irq("oneshot_irq_cleared", 1'b0);

        // Auto-reload, PRESET=3: one-cycle pulse every 6 cycles.
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk_irq("reload_irq", (k % 6) == 5);
        end
        bus_write(2'd0, 32'h8);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_irq("reload_stopped_irq", 1'b0);
        end
        chk_reg("reload_stopped_count", 2'd2, 32'd3);

        // Masked interrupt, PRESET=2.
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_irq("mask_irq", 1'b0);
        end
        chk_reg("mask_count", 2'd2, 32'h0);
        chk_reg("mask_ctrl_en_clr", 2'd0, 32'h0);
        bus_write(2'd0, 32'h8);
        chk_irq("mask_unmask_irq", 1'b0);

        // Stop mid-count and read-only checks, PRESET=100.
        bus_write(2'd1, 32'd100);
        bus_write(2'd0, 32'h1);
        tick();
        tick();
        chk_reg("stop_count_start", 2'd2, 32'd100);
        for (int k = 0; k < 9; k++) begin
            tick();
        end
        chk_reg("stop_count_91", 2'd2, 32'd91);
        bus_write(2'd0, 32'h0);
        chk_reg("stop_count_90", 2'd2, 32'd90);
        tick();
        chk_reg("stop_frozen", 2'd2, 32'd90);
        tick();
        chk_reg("stop_frozen2", 2'd2, 32'd90);
        bus_write(2'd2, 32'h1234);
        chk_reg("count_readonly", 2'd2, 32'd90);
        bus_write(2'd3, 32'hFFFF_FFFF);
        chk_reg("off3_zero", 2'd3, 32'h0);
        chk_reg("off3_ctrl_untouched", 2'd0, 32'h0);
        chk_reg("off3_preset_untouched", 2'd1, 32'd100);

        // Read-during-write: old value visible in the write cycle.
        Addr = Base | 30'd1;
        WE   = 1'b1;
        Din  = 32'd50;
        chk_reg("rdw_old", 2'd1, 32'd100);
        tick();
        WE   = 1'b0;
        Din  = '0;
        chk_reg("rdw_new", 2'd1, 32'd50);

        // Mid-run PRESET write does not disturb the current run.
        bus_write(2'd0, 32'h9);
        tick();
        tick();
        chk_reg("midrun_start", 2'd2, 32'd50);
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        chk_reg("midrun_40", 2'd2, 32'd40);
        bus_write(2'd1, 32'd7);
        chk_reg("midrun_39", 2'd2, 32'd39);
        chk_reg("midrun_preset", 2'd1, 32'd7);
        for (int k = 0; k < 39; k++) begin
            tick();
        end
        chk_reg("midrun_end", 2'd2, 32'h0);
        chk_irq("midrun_irq", 1'b1);
        tick();
        bus_write(2'd0, 32'h9);
        chk_irq("rerun_irq_clr", 1'b0);
        tick();
        tick();
        chk_reg("rerun_new_preset", 2'd2, 32'd7);
        tick();
        tick();
        chk_reg("rerun_count5", 2'd2, 32'd5);

        // Reset mid-count, with a CTRL write on the same edge.
        reset = 1'b1;
        WE    = 1'b1;
        Din   = 32'hF;
        Addr  = Base;
        tick();
        chk_reg("rst_ctrl", 2'd0, 32'h0);
        chk_reg("rst_preset", 2'd1, 32'h0);
        chk_reg("rst_count", 2'd2, 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b0;
        WE    = 1'b0;
        Din   = '0;
        tick();
        tick();
        chk_reg("rst_count_idle", 2'd2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
